note_distributor: RTL and testbench

NOTE_DISTRIBUTOR -- requirements
Module: note_distributor

---
 rtl/note_distributor.sv | 264 ++++++++++++++++++++++++++
 tb/tb_note_distributor.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_distributor.sv
`default_nettype none
// ============================================================================
//  Module   : note_distributor
//  Purpose  : Takes {note, duration} pairs from a song reader through a
//             2-entry FIFO and hands each one to a free downstream note player.
//             Players are chosen round-robin. If every player stays busy for
//             too long, the player that has gone longest since its last load
//             is stolen. Rests and zero-length notes are discarded without
//             producing a load pulse.
//  Ports    : clk, reset          - single clock, synchronous active-high reset
//             play_enable         - gates dispatch, pops and the stall counter
//             note_in/duration_in - 6-bit note / duration, qualified by note_valid
//             note_ready          - FIFO not full
//             player_playing      - per-player busy flags
//             load_note           - one-hot, one-cycle load pulse
//             note_out/duration_out - note for the player just loaded (held)
//             steal_count         - saturating count of steals since reset
//  Revision : 1.0 - initial release
// ============================================================================
module note_distributor #(
  parameter int NUM_PLAYERS = 3,
  parameter int STALL_LIMIT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   play_enable,
  input  logic [5:0]             note_in,
  input  logic [5:0]             duration_in,
  input  logic                   note_valid,
  output logic                   note_ready,
  input  logic [NUM_PLAYERS-1:0] player_playing,
  output logic [NUM_PLAYERS-1:0] load_note,
  output logic [5:0]             note_out,
  output logic [5:0]             duration_out,
  output logic [7:0]             steal_count
);

  localparam int                     c_IDX_W    = 3;  // enough for up to 8 players
  localparam logic [7:0]             c_STALL_LAST = 8'(STALL_LIMIT - 1);
  localparam logic [NUM_PLAYERS-1:0] c_ONE_HOT0 = {{(NUM_PLAYERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_WAIT = 2'd2,
    S_LOAD = 2'd3
  } state_t;

  state_t                   r_state;

  // FIFO
  logic [5:0]               r_fifo_note [2];
  logic [5:0]               r_fifo_dur  [2];
  logic                     r_rd_ptr;
  logic                     r_wr_ptr;
  logic [1:0]               r_count;

  // Player bookkeeping
  logic [c_IDX_W-1:0]       r_last;               // index of the last player loaded
  logic [1:0]               r_mask [NUM_PLAYERS]; // nonzero = recently loaded
  logic [NUM_PLAYERS-1:0]   r_loaded;             // player has been loaded since reset
  logic [c_IDX_W-1:0]       r_rank [NUM_PLAYERS]; // 0 = most recently loaded
  logic [7:0]               r_stall;

  // Registered outputs
  logic [NUM_PLAYERS-1:0]   r_load_note;
  logic [5:0]               r_note_out;
  logic [5:0]               r_dur_out;
  logic [7:0]               r_steal_count;

  logic                     w_push;
  logic                     w_pop;
  logic [1:0]               w_count_next;
  logic [5:0]               w_head_note;
  logic [5:0]               w_head_dur;
  logic                     w_head_rest;
  logic [NUM_PLAYERS-1:0]   w_elig;
  logic                     w_rr_found;
  logic [c_IDX_W-1:0]       w_rr_sel;
  logic                     w_never;
  logic [c_IDX_W-1:0]       w_old_sel;
  logic [c_IDX_W-1:0]       w_max_rank;
  logic                     w_do_load;
  logic                     w_do_steal;
  logic                     w_rest_pop;
  logic [c_IDX_W-1:0]       w_sel;

  assign note_ready   = (r_count != 2'd2);
  assign load_note    = r_load_note;
  assign note_out     = r_note_out;
  assign duration_out = r_dur_out;
  assign steal_count  = r_steal_count;

  assign w_push       = note_valid && note_ready;
  assign w_pop        = w_rest_pop || w_do_load;
  assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_head_note  = r_fifo_note[r_rd_ptr];
  assign w_head_dur   = r_fifo_dur[r_rd_ptr];
  assign w_head_rest  = (w_head_note == 6'd0) || (w_head_dur == 6'd0);

  generate
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_elig
      assign w_elig[gi] = !player_playing[gi] && (r_mask[gi] == 2'd0);
    end
  endgenerate

  // Round-robin search starting just after the last player loaded.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_sel   = '0;
    for (int k = 1; k <= NUM_PLAYERS; k++) begin
      if (!w_rr_found && w_elig[(int'(r_last) + k) % NUM_PLAYERS]) begin
        w_rr_found = 1'b1;
        w_rr_sel   = c_IDX_W'((int'(r_last) + k) % NUM_PLAYERS);
      end
    end
  end

  // Oldest player: lowest-index never-loaded player, otherwise the loaded
  // player with the highest recency rank (ranks are unique once loaded).
  always_comb begin
    w_never    = 1'b0;
    w_old_sel  = '0;
    w_max_rank = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!r_loaded[i] && !w_never) begin
        w_never   = 1'b1;
        w_old_sel = c_IDX_W'(i);
      end
    end
    if (!w_never) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (r_rank[i] > w_max_rank) begin
          w_max_rank = r_rank[i];
          w_old_sel  = c_IDX_W'(i);
        end
      end
    end
  end

  // Dispatch decision for this cycle.
  always_comb begin
    w_do_load  = 1'b0;
    w_do_steal = 1'b0;
    w_rest_pop = 1'b0;
    w_sel      = '0;
    if (play_enable) begin
      case (r_state)
        S_EVAL: begin
          if (r_count != 2'd0) begin
            if (w_head_rest) begin
              w_rest_pop = 1'b1;
            end else if (w_rr_found) begin
              w_do_load = 1'b1;
              w_sel     = w_rr_sel;
            end
          end
        end
        S_WAIT: begin
          if (w_rr_found) begin
            w_do_load = 1'b1;
            w_sel     = w_rr_sel;
          end else if (r_stall >= c_STALL_LAST) begin
            w_do_load  = 1'b1;
            w_do_steal = 1'b1;
            w_sel      = w_old_sel;
          end
        end
        default: ;
      endcase
    end
  end

  // FIFO storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_note[r_wr_ptr] <= note_in;
      r_fifo_dur[r_wr_ptr]  <= duration_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rd_ptr      <= 1'b0;
      r_wr_ptr      <= 1'b0;
      r_count       <= 2'd0;
      r_last        <= c_IDX_W'(NUM_PLAYERS - 1);
      r_loaded      <= '0;
      r_stall       <= 8'd0;
      r_load_note   <= '0;
      r_note_out    <= 6'd0;
      r_dur_out     <= 6'd0;
      r_steal_count <= 8'd0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_mask[i] <= 2'd0;
        r_rank[i] <= '0;
      end
    end else begin
      r_load_note <= '0;
      r_count     <= w_count_next;
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;

      // Masks count down the pulse cycle plus the two cycles after it.
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (r_mask[i] != 2'd0) r_mask[i] <= r_mask[i] - 2'd1;
      end

      if (w_do_load) begin
        r_load_note    <= c_ONE_HOT0 << w_sel;
        r_note_out     <= w_head_note;
        r_dur_out      <= w_head_dur;
        r_last         <= w_sel;
        r_mask[w_sel]  <= 2'd3;
        r_loaded[w_sel] <= 1'b1;
        r_stall        <= 8'd0;
        // Everyone more recent than the loaded player ages by one.
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (i == int'(w_sel)) begin
            r_rank[i] <= '0;
          end else if (r_loaded[i] && (!r_loaded[w_sel] || r_rank[i] < r_rank[w_sel])) begin
            r_rank[i] <= r_rank[i] + 1'b1;
          end
        end
        if (w_do_steal && r_steal_count != 8'hFF) begin
          r_steal_count <= r_steal_count + 8'd1;
        end
      end

      case (r_state)
        // IDLE only means "FIFO empty", so it follows the FIFO even while
        // dispatch is disabled; all other transitions wait for play_enable.
        S_IDLE: begin
          if (w_count_next != 2'd0) r_state <= S_EVAL;
        end
        S_EVAL: begin
          if (play_enable) begin
            if (w_do_load) begin
              r_state <= S_LOAD;
            end else if (r_count == 2'd0 || w_rest_pop) begin
              r_state <= (w_count_next != 2'd0) ? S_EVAL : S_IDLE;
            end else begin
              r_state <= S_WAIT;
              r_stall <= 8'd0;
            end
          end
        end
        S_WAIT: begin
          if (play_enable) begin
            if (w_do_load) r_state <= S_LOAD;
            else           r_stall <= r_stall + 8'd1;
          end
        end
        S_LOAD: begin
          if (play_enable) r_state <= (w_count_next != 2'd0) ? S_EVAL : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_note_distributor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_note_distributor
//  Purpose  : Self-checking bench for note_distributor: a cycle model built on
//             a queue, per-player load timestamps and masking deadlines is
//             compared with the DUT every cycle; directed scenarios add
//             hand-computed expectations on pulse timing, order and counts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_note_distributor;

  localparam int N     = 3;
  localparam int LIMIT = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         play_enable = 1'b1;
  logic [5:0]   note_in = 6'd0;
  logic [5:0]   duration_in = 6'd0;
  logic         note_valid = 1'b0;
  logic         note_ready;
  logic [N-1:0] player_playing = '0;
  logic [N-1:0] load_note;
  logic [5:0]   note_out;
  logic [5:0]   duration_out;
  logic [7:0]   steal_count;

  int total = 0;
  int bad   = 0;
  int tcyc  = 0;
  int t0    = 0;

  note_distributor #(.NUM_PLAYERS(N), .STALL_LIMIT(LIMIT)) dut (
    .clk           (clk),
    .reset         (reset),
    .play_enable   (play_enable),
    .note_in       (note_in),
    .duration_in   (duration_in),
    .note_valid    (note_valid),
    .note_ready    (note_ready),
    .player_playing(player_playing),
    .load_note     (load_note),
    .note_out      (note_out),
    .duration_out  (duration_out),
    .steal_count   (steal_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, tcyc);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [5:0] n;
    logic [5:0] d;
  } ent_t;

  ent_t mq[$];
  int   last_rr;
  int   last_load [N];   // cycle of most recent pulse, -1 = never
  int   mask_until[N];   // player unavailable through this cycle
  bit   busy, waiting, mv;
  int   wcnt;
  int   e_load, e_note, e_dur, e_steal, e_ready;

  function automatic int pick_rr();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last_rr + k) % N;
      if (!player_playing[i] && tcyc > mask_until[i]) return i;
    end
    return -1;
  endfunction

  function automatic int oldest();
    int best;
    best = 0;
    for (int i = 1; i < N; i++) if (last_load[i] < last_load[best]) best = i;
    return best;
  endfunction

  always @(negedge clk) begin
    ent_t h;
    int   sel;
    bit   pushed;
    if (mv) begin
      chk("load_note", int'(load_note), e_load);
      chk("note_out", int'(note_out), e_note);
      chk("duration_out", int'(duration_out), e_dur);
      chk("steal_count", int'(steal_count), e_steal);
      chk("note_ready", int'(note_ready), e_ready);
    end
    if (reset) begin
      mq.delete();
      busy = 0; waiting = 0; wcnt = 0; last_rr = N - 1;
      for (int i = 0; i < N; i++) begin last_load[i] = -1; mask_until[i] = -100; end
      e_load = 0; e_note = 0; e_dur = 0; e_steal = 0; e_ready = 1;
      mv = 1;
    end else begin
      pushed = note_valid && (mq.size() < 2);
      sel    = -1;
      e_load = 0;
      if (busy) begin
        if (play_enable) busy = 0;
      end else if (play_enable && mq.size() > 0) begin
        h = mq[0];
        if (h.n == 0 || h.d == 0) begin
          void'(mq.pop_front());
        end else begin
          sel = pick_rr();
          if (sel < 0) begin
            if (!waiting) begin
              waiting = 1; wcnt = 0;
            end else begin
              wcnt++;
              if (wcnt >= LIMIT) begin
                sel = oldest();
                if (e_steal < 255) e_steal++;
              end
            end
          end
          if (sel >= 0) begin
            e_load = 1 << sel; e_note = h.n; e_dur = h.d;
            void'(mq.pop_front());
            busy = 1; waiting = 0; last_rr = sel;
            last_load[sel]  = tcyc + 1;
            mask_until[sel] = tcyc + 3;
          end
        end
      end
      if (pushed) mq.push_back(ent_t'({note_in, duration_in}));
      e_ready = (mq.size() < 2) ? 1 : 0;
    end
  end

  // ---------------------------------------------------------- pulse recorder
  int r_t[$], r_l[$], r_n[$];
  always @(negedge clk) begin
    if (!reset && load_note != '0) begin
      r_t.push_back(tcyc - t0);
      r_l.push_back(int'(load_note));
      r_n.push_back(int'(note_out));
    end
  end

  task automatic clear_rec();
    r_t.delete(); r_l.delete(); r_n.delete();
  endtask

  task automatic exp_pulse(input string name, input int idx, input int t, input int ld, input int nt);
    int at, al, an;
    at = (idx < r_t.size()) ? r_t[idx] : -1;
    al = (idx < r_l.size()) ? r_l[idx] : -1;
    an = (idx < r_n.size()) ? r_n[idx] : -1;
    if (t >= 0) chk({name, "_cycle"}, at, t);
    chk({name, "_player"}, al, ld);
    chk({name, "_note"}, an, nt);
  endtask

  // ------------------------------------------------------------ stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; note_valid = 1'b0; play_enable = 1'b1; player_playing = '0;
    step(); step();
    reset = 1'b0;
    t0 = tcyc;
    clear_rec();
  endtask

  task automatic drive(input bit v, input int n, input int d);
    note_valid = v; note_in = 6'(n); duration_in = 6'(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit done;

    // Single note to idle players, plus reset values.
    do_reset();
    drive(1, 12, 8);
    @(negedge clk);
    chk("rst_load_note", int'(load_note), 0);
    chk("rst_note_out", int'(note_out), 0);
    chk("rst_duration_out", int'(duration_out), 0);
    chk("rst_steal_count", int'(steal_count), 0);
    chk("rst_note_ready", int'(note_ready), 1);
    step(); drive(0, 0, 0);
    repeat (6) step();
    chk("single_count", r_t.size(), 1);
    exp_pulse("single", 0, 2, 1, 12);
    chk("single_duration", int'(duration_out), 8);

    // Three back-to-back notes rotate across the players.
    do_reset();
    drive(1, 5, 4); step();
    drive(1, 7, 4); step();
    drive(1, 9, 4); step();
    drive(0, 0, 0);
    repeat (8) step();
    chk("b2b_count", r_t.size(), 3);
    exp_pulse("b2b0", 0, 2, 1, 5);
    exp_pulse("b2b1", 1, 4, 2, 7);
    exp_pulse("b2b2", 2, 6, 4, 9);

    // All players busy: steal after the stall limit, then steal the next oldest.
    do_reset();
    player_playing = 3'b111;
    drive(1, 20, 6); step();
    drive(0, 0, 0);
    repeat (24) step();
    chk("steal1_count", r_t.size(), 1);
    exp_pulse("steal1", 0, 18, 1, 20);
    chk("steal1_steal_count", int'(steal_count), 1);
    drive(1, 21, 1); step();
    drive(0, 0, 0);
    repeat (22) step();
    chk("steal2_count", r_t.size(), 2);
    exp_pulse("steal2", 1, -1, 2, 21);
    chk("steal2_steal_count", int'(steal_count), 2);

    // Rest is dropped without a pulse and delays the following note by one cycle.
    do_reset();
    drive(1, 0, 10); step();
    drive(1, 3, 2); step();
    drive(0, 0, 0);
    repeat (6) step();
    chk("rest_count", r_t.size(), 1);
    exp_pulse("rest", 0, 3, 1, 3);
    chk("rest_duration", int'(duration_out), 2);

    // Fill with dispatch disabled, then drain in order.
    do_reset();
    play_enable = 1'b0;
    drive(1, 1, 1); step();
    drive(1, 2, 2); step();
    drive(1, 3, 3);
    @(negedge clk);
    chk("fill_ready_full", int'(note_ready), 0);
    step(); step();
    @(negedge clk);
    chk("fill_ready_held", int'(note_ready), 0);
    chk("fill_no_pulse", r_t.size(), 0);
    step();
    play_enable = 1'b1;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      acc = note_ready;
      step();
      if (acc) begin
        drive(0, 0, 0);
        done = 1;
      end
    end
    chk("fill_third_accepted", int'(done), 1);
    repeat (8) step();
    chk("fill_count", r_t.size(), 3);
    exp_pulse("fill0", 0, -1, 1, 1);
    exp_pulse("fill1", 1, -1, 2, 2);
    exp_pulse("fill2", 2, -1, 4, 3);

    // Reset while waiting with a full FIFO and a nonzero steal count.
    do_reset();
    player_playing = 3'b111;
    drive(1, 4, 4); step();
    drive(1, 6, 6); step();
    drive(1, 8, 8);
    repeat (17) step();         // now in cycle 19
    drive(0, 0, 0);
    repeat (2) step();          // cycle 21
    @(negedge clk);
    chk("wait_steal_before", int'(steal_count), 1);
    chk("wait_fifo_full", int'(note_ready), 0);
    step();                     // cycle 22
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("wrst_load_note", int'(load_note), 0);
    chk("wrst_note_ready", int'(note_ready), 1);
    chk("wrst_steal_count", int'(steal_count), 0);
    repeat (4) step();

    // Mixed traffic pattern: rests, zero durations, enable gaps, busy players.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      play_enable    = !(i >= 20 && i < 26);
      player_playing = 3'((i / 5) % 8);
      drive((i % 4) != 3, (i % 7 == 0) ? 0 : i + 1, (i % 9 == 4) ? 0 : (i % 5) + 1);
      step();
    end
    drive(0, 0, 0);
    player_playing = '0;
    play_enable    = 1'b1;
    repeat (10) step();
    chk("mix_drained", int'(note_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
